nios2_cpu_div_cell: RTL and testbench

//   Iterative radix-2 integer divider; inverse-direction companion to the CPU multiply cell.

---
 rtl/nios2_cpu_div_cell.sv | 172 +++++++++++++++++
 tb/tb_nios2_cpu_div_cell.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II DIV/DIVU instructions.
// One quotient bit per clock; start/done handshake with a busy flag for pipeline stall.
// Signed operands are divided as magnitudes and the signs are restored in a fixup cycle.

module nios2_cpu_div_cell #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic              div_kill,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_quot,
  output logic [DATA_W-1:0] div_rem,
  output logic              div_by_zero
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFixup,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  // Original dividend, returned untouched as the remainder on divide-by-zero.
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] quot_out_q, quot_out_d;
  logic [DATA_W-1:0] rem_out_q, rem_out_d;
  logic              dbz_q, dbz_d;

  // Datapath helpers
  logic [DATA_W:0]   rem_sh;
  logic              rem_ge;
  logic [DATA_W-1:0] src1_abs;
  logic [DATA_W-1:0] src2_abs;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  // Shift/compare step, operand magnitudes and sign restoration
  always_comb begin
    rem_sh   = {rem_q, quo_q[DATA_W-1]};
    rem_ge   = (rem_sh >= {1'b0, dvs_q});
    src1_abs = (div_signed && E_src1[DATA_W-1]) ? -E_src1 : E_src1;
    src2_abs = (div_signed && E_src2[DATA_W-1]) ? -E_src2 : E_src2;
    quo_fix  = neg_quo_q ? -quo_q : quo_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  // Next-state logic for the FSM, datapath and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    if (div_kill) begin
      // Flush: abandon any operation, drop a coincident start, keep old results.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_start) begin
            state_d   = StRun;
            busy_d    = 1'b1;
            cnt_d     = CntW'(DATA_W);
            quo_d     = src1_abs;
            rem_d     = '0;
            dvs_d     = src2_abs;
            dvd_d     = E_src1;
            neg_quo_d = div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
            neg_rem_d = div_signed & E_src1[DATA_W-1];
          end
        end
        StRun: begin
          // quo_q doubles as the dividend shift register; quotient bits enter at the LSB.
          quo_d = {quo_q[DATA_W-2:0], rem_ge};
          rem_d = rem_ge ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_d = StFixup;
          end
        end
        StFixup: begin
          state_d = StDone;
          done_d  = 1'b1;
          if (dvs_q == '0) begin
            quot_out_d = '1;
            rem_out_d  = dvd_q;
            dbz_d      = 1'b1;
          end else begin
            quot_out_d = quo_fix;
            rem_out_d  = rem_fix;
            dbz_d      = 1'b0;
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign div_busy    = busy_q;
  assign div_done    = done_q;
  assign div_quot    = quot_out_q;
  assign div_rem     = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Directed and small randomized bench for nios2_cpu_div_cell (DATA_W = 32).

module tb_nios2_cpu_div_cell;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] E_src1;
  logic [W-1:0] E_src2;
  logic         div_start;
  logic         div_signed;
  logic         div_kill;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic         div_by_zero;

  int n_assert;
  int n_fail;

  nios2_cpu_div_cell #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_src1     (E_src1),
    .E_src2     (E_src2),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_kill   (div_kill),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the DUT to return to IDLE before a new start.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while (div_busy && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Counts edges until div_done is seen after the #1 sample point; start_lat edges already spent.
  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (!div_done && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  // Issues one operation; lat = edges from the accepting edge (inclusive) to the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       output int lat);
    wait_idle();
    @(negedge clk);
    E_src1     = a;
    E_src2     = b;
    div_signed = sgn;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = 1'b0;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;

    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    E_src1     = '0;
    E_src2     = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_kill   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    check("rst_quot", div_quot, 32'd0);
    check("rst_rem", div_rem, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // DIVU 100 / 7
    do_op(32'd100, 32'd7, 1'b0, lat);
    check("u100_7_lat", lat, W + 2);
    check("u100_7_quot", div_quot, 32'd14);
    check("u100_7_rem", div_rem, 32'd2);
    check("u100_7_dbz", {31'd0, div_by_zero}, 32'd0);
    check("busy_in_done", {31'd0, div_busy}, 32'd1);
    @(posedge clk);
    #1;
    check("done_pulse_one_cycle", {31'd0, div_done}, 32'd0);
    check("busy_drop", {31'd0, div_busy}, 32'd0);

    // DIV -100 / 7
    do_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat);
    check("s_m100_7_quot", div_quot, 32'hFFFF_FFF2);
    check("s_m100_7_rem", div_rem, 32'hFFFF_FFFE);

    // DIV 7 / -2 and -7 / -2
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    check("s_7_m2_quot", div_quot, 32'hFFFF_FFFD);
    check("s_7_m2_rem", div_rem, 32'd1);
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat);
    check("s_m7_m2_quot", div_quot, 32'd3);
    check("s_m7_m2_rem", div_rem, 32'hFFFF_FFFF);

    // Signed overflow and unsigned max
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    check("ovf_quot", div_quot, 32'h8000_0000);
    check("ovf_rem", div_rem, 32'd0);
    check("ovf_dbz", {31'd0, div_by_zero}, 32'd0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check("umax_quot", div_quot, 32'hFFFF_FFFF);
    check("umax_rem", div_rem, 32'd0);

    // Divide by zero, unsigned and signed
    do_op(32'h0000_1234, 32'd0, 1'b0, lat);
    check("dbz_lat", lat, W + 2);
    check("dbz_quot", div_quot, 32'hFFFF_FFFF);
    check("dbz_rem", div_rem, 32'h0000_1234);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    do_op(32'hFFFF_FF9C, 32'd0, 1'b1, lat);
    check("sdbz_quot", div_quot, 32'hFFFF_FFFF);
    check("sdbz_rem", div_rem, 32'hFFFF_FF9C);
    check("sdbz_flag", {31'd0, div_by_zero}, 32'd1);

    // Kill at RUN cycle 10: no done, previous outputs held
    wait_idle();
    @(negedge clk);
    E_src1     = 32'd1000;
    E_src2     = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    check("busy_after_accept", {31'd0, div_busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_kill = 1'b1;
    @(posedge clk);
    #1;
    div_kill = 1'b0;
    check("kill_busy", {31'd0, div_busy}, 32'd0);
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (div_done) seen++;
    end
    check("kill_no_done", seen, 32'd0);
    check("kill_quot_held", div_quot, 32'hFFFF_FFFF);
    check("kill_rem_held", div_rem, 32'hFFFF_FF9C);
    check("kill_dbz_held", {31'd0, div_by_zero}, 32'd1);

    // Kill together with start in IDLE drops the start
    @(negedge clk);
    E_src1    = 32'd50;
    E_src2    = 32'd5;
    div_start = 1'b1;
    div_kill  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    div_kill  = 1'b0;
    check("kill_start_busy", {31'd0, div_busy}, 32'd0);

    // Start mid-RUN is ignored
    @(negedge clk);
    E_src1     = 32'd200;
    E_src2     = 32'd10;
    div_signed = 1'b0;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    E_src1     = 32'd999;
    E_src2     = 32'd1;
    div_signed = 1'b1;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    wait_done(6, lat);
    check("ign_lat", lat, W + 2);
    check("ign_quot", div_quot, 32'd20);
    check("ign_rem", div_rem, 32'd0);

    // Reset in RUN cycle 5
    wait_idle();
    @(negedge clk);
    E_src1     = 32'd500;
    E_src2     = 32'd7;
    div_signed = 1'b0;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mrst_busy", {31'd0, div_busy}, 32'd0);
    check("mrst_done", {31'd0, div_done}, 32'd0);
    check("mrst_quot", div_quot, 32'd0);
    check("mrst_rem", div_rem, 32'd0);
    check("mrst_dbz", {31'd0, div_by_zero}, 32'd0);
    do_op(32'd81, 32'd9, 1'b0, lat);
    check("post_rst_lat", lat, W + 2);
    check("post_rst_quot", div_quot, 32'd9);
    check("post_rst_rem", div_rem, 32'd0);

    // Randomized pairs against a reference model
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0 && rs) rb = -rb;
      ref_div(ra, rb, rs, eq, er, ez);
      do_op(ra, rb, rs, lat);
      check("rnd_lat", lat, W + 2);
      check("rnd_quot", div_quot, eq);
      check("rnd_rem", div_rem, er);
      check("rnd_dbz", {31'd0, div_by_zero}, {31'd0, ez});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
